decoder32_regbank: RTL and testbench

Write-side counterpart to the 32:1 read mux: a 5-to-32 address decoder driving a bank of 32 N-bit registers.
- One write port per cycle, decoded one-hot to a single register.
- All 32 register values are exposed on a flattened bus, which feeds the 32-input read muxes.
- A sequential bulk-clear engine zeroes the bank one register per cycle, with a busy handshake.
- Sits in the CPU register-file path, between writeback and the read-port muxes.

---
 rtl/decoder32_regbank.sv | 80 ++++++++
 tb/tb_decoder32_regbank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder32_regbank.sv
// 5-to-32 write decoder feeding a bank of 32 N-bit registers,
// with a one-register-per-cycle bulk-clear sweep and busy handshake.
module decoder32_regbank #(
  parameter int unsigned N        = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_ena,
  input  logic [4:0]      wr_addr,
  input  logic [N-1:0]    wr_data,
  input  logic            clr_req,
  output logic            busy,
  output logic            wr_err,
  output logic [31:0]     wr_onehot,
  output logic [32*N-1:0] q_flat
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        wr_err_q, wr_err_d;
  logic [31:0] wr_onehot_q, wr_onehot_d;
  logic [N-1:0] regs_q [32];
  logic [N-1:0] regs_d [32];
  logic        wr_acc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clr_req) state_d = CLEAR;
      CLEAR: if (cnt_q == 5'd31) state_d = IDLE;
    endcase
  end

  // busy_q tracks state_q, so gating writes on it blocks the whole sweep
  always_comb begin
    wr_acc      = wr_ena && !busy_q;
    busy_d      = (state_d == CLEAR);
    cnt_d       = (state_q == CLEAR) ? cnt_q + 5'd1 : 5'd0;
    wr_err_d    = wr_ena && busy_q;
    wr_onehot_d = wr_acc ? (32'd1 << wr_addr) : 32'd0;
    regs_d      = regs_q;
    if (wr_acc)            regs_d[wr_addr] = wr_data;
    if (state_q == CLEAR)  regs_d[cnt_q]   = '0;
    if (ZERO_REG)          regs_d[0]       = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 5'd0;
      busy_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      wr_onehot_q <= 32'd0;
      for (int k = 0; k < 32; k++) regs_q[k] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      wr_err_q    <= wr_err_d;
      wr_onehot_q <= wr_onehot_d;
      for (int k = 0; k < 32; k++) regs_q[k] <= regs_d[k];
    end
  end

  assign busy      = busy_q;
  assign wr_err    = wr_err_q;
  assign wr_onehot = wr_onehot_q;

  for (genvar k = 0; k < 32; k++) begin : g_flat
    assign q_flat[k*N +: N] = regs_q[k];
  end

endmodule

// File: tb/tb_decoder32_regbank.sv
// Randomized bench for decoder32_regbank against a
// rule-level model of the bank, sweep and write flags.
module tb_decoder32_regbank;

  localparam int N = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_ena;
  logic [4:0]      wr_addr;
  logic [N-1:0]    wr_data;
  logic            clr_req;
  logic            busy;
  logic            wr_err;
  logic [31:0]     wr_onehot;
  logic [32*N-1:0] q_flat;

  int n_cmp = 0;
  int n_fail = 0;

  // model state: bank contents and number of sweep cycles still pending
  logic [N-1:0] m_reg [32];
  int           m_left;
  logic         m_err;
  logic [31:0]  m_oh;

  decoder32_regbank #(.N(N), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy),
    .wr_err(wr_err), .wr_onehot(wr_onehot), .q_flat(q_flat)
  );

  always #5 clk = ~clk;

  function automatic logic [32*N-1:0] exp_flat();
    logic [32*N-1:0] f;
    for (int k = 0; k < 32; k++) f[k*N +: N] = m_reg[k];
    return f;
  endfunction

  task automatic step(input logic r, input logic we,
                      input logic [4:0] a, input logic [N-1:0] d,
                      input logic c);
    logic acc;
    rst = r; wr_ena = we; wr_addr = a; wr_data = d; clr_req = c;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 32; k++) m_reg[k] = '0;
      m_left = 0; m_err = 1'b0; m_oh = '0;
    end else begin
      acc   = we && (m_left == 0);
      m_err = we && (m_left != 0);
      m_oh  = acc ? (32'd1 << a) : 32'd0;
      if (m_left != 0) begin
        m_reg[32 - m_left] = '0;
        m_left--;
      end else if (c) begin
        m_left = 32;
      end
      if (acc && a != 5'd0) m_reg[a] = d;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, '0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 5'($urandom), N'($urandom), 1'b1);
    step(1'b1, 1'b1, 5'($urandom), N'($urandom), 1'b0);
    idle();
    n_cmp++;
    if (q_flat !== '0) begin
      n_fail++; $display("FAIL reset_q got %h want 0", q_flat);
    end
    n_cmp++;
    if ({busy, wr_err, wr_onehot} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b err=%b oh=%h want 0",
               busy, wr_err, wr_onehot);
    end
  endtask

  task automatic test_single_write();
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (q_flat[191:160] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_reg5 got %h want deadbeef", q_flat[191:160]);
    end
    n_cmp++;
    if (wr_onehot !== 32'h20) begin
      n_fail++; $display("FAIL single_oh got %h want 20", wr_onehot);
    end
    n_cmp++;
    if (q_flat !== exp_flat()) begin
      n_fail++; $display("FAIL single_bank got %h want %h", q_flat, exp_flat());
    end
    idle();
    n_cmp++;
    if (wr_onehot !== 32'd0) begin
      n_fail++; $display("FAIL single_oh_drop got %h want 0", wr_onehot);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    for (int k = 0; k < 32; k++) begin
      step(1'b0, 1'b1, 5'(k), N'(32'h100 + k), 1'b0);
      want = 32'd1 << k;
      n_cmp++;
      if (wr_onehot !== want) begin
        n_fail++;
        $display("FAIL b2b_oh[%0d] got %h want %h", k, wr_onehot, want);
      end
    end
    n_cmp++;
    if (q_flat[N-1:0] !== '0) begin
      n_fail++; $display("FAIL b2b_reg0 got %h want 0", q_flat[N-1:0]);
    end
    for (int k = 1; k < 32; k++) begin
      n_cmp++;
      if (q_flat[k*N +: N] !== N'(32'h100 + k)) begin
        n_fail++;
        $display("FAIL b2b_reg%0d got %h want %h", k, q_flat[k*N +: N],
                 N'(32'h100 + k));
      end
    end
  endtask

  task automatic test_clear_blocked();
    int busy_cycles = 0;
    int err_pulses = 0;
    for (int k = 0; k < 32; k++)
      step(1'b0, 1'b1, 5'(k), N'($urandom) | N'(1), 1'b0);
    step(1'b0, 1'b0, 5'd0, '0, 1'b1);
    for (int i = 1; i <= 36; i++) begin
      busy_cycles += (busy === 1'b1) ? 1 : 0;
      n_cmp++;
      if (q_flat !== exp_flat() || busy !== (m_left != 0)) begin
        n_fail++;
        $display("FAIL clr_cyc%0d got busy=%b q=%h want busy=%b q=%h",
                 i, busy, q_flat, m_left != 0, exp_flat());
      end
      if (i == 10) step(1'b0, 1'b1, 5'($urandom), N'($urandom), 1'b0);
      else         idle();
      err_pulses += (wr_err === 1'b1) ? 1 : 0;
    end
    n_cmp++;
    if (busy_cycles != 32) begin
      n_fail++; $display("FAIL clr_busy_len got %0d want 32", busy_cycles);
    end
    n_cmp++;
    if (err_pulses != 1) begin
      n_fail++; $display("FAIL clr_err_pulses got %0d want 1", err_pulses);
    end
    n_cmp++;
    if (q_flat !== '0) begin
      n_fail++; $display("FAIL clr_final got %h want 0", q_flat);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b1, 5'd3, N'(32'hA5), 1'b1);
    n_cmp++;
    if (busy !== 1'b1 || q_flat[3*N +: N] !== N'(32'hA5)) begin
      n_fail++;
      $display("FAIL simul_start got busy=%b reg3=%h want 1/a5",
               busy, q_flat[3*N +: N]);
    end
    for (int i = 0; i < 34; i++) begin
      idle();
      n_cmp++;
      if (q_flat !== exp_flat() || busy !== (m_left != 0)) begin
        n_fail++;
        $display("FAIL simul_cyc%0d got busy=%b reg3=%h want busy=%b reg3=%h",
                 i, busy, q_flat[3*N +: N], m_left != 0, m_reg[3]);
      end
    end
    n_cmp++;
    if (q_flat !== '0) begin
      n_fail++; $display("FAIL simul_final got %h want 0", q_flat);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [N-1:0] d;
    for (int k = 1; k < 32; k++)
      step(1'b0, 1'b1, 5'(k), N'($urandom) | N'(1), 1'b0);
    step(1'b0, 1'b0, 5'd0, '0, 1'b1);
    for (int i = 1; i < 17; i++) idle();
    step(1'b1, 1'b0, 5'd0, '0, 1'b0);
    n_cmp++;
    if (busy !== 1'b0 || q_flat !== '0) begin
      n_fail++;
      $display("FAIL midrst got busy=%b q=%h want 0/0", busy, q_flat);
    end
    d = N'($urandom);
    step(1'b0, 1'b1, 5'd9, d, 1'b0);
    n_cmp++;
    if (q_flat[9*N +: N] !== d || wr_onehot !== 32'h200) begin
      n_fail++;
      $display("FAIL midrst_write got reg9=%h oh=%h want %h/200",
               q_flat[9*N +: N], wr_onehot, d);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
           5'($urandom), N'($urandom), ($urandom_range(0, 39) == 0));
      n_cmp++;
      if (q_flat !== exp_flat() || busy !== (m_left != 0) ||
          wr_err !== m_err || wr_onehot !== m_oh) begin
        n_fail++;
        $display("FAIL rand%0d got b=%b e=%b oh=%h want b=%b e=%b oh=%h bank_ok=%b",
                 i, busy, wr_err, wr_onehot, m_left != 0, m_err, m_oh,
                 q_flat === exp_flat());
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    for (int k = 0; k < 32; k++) m_reg[k] = '0;
    m_left = 0; m_err = 1'b0; m_oh = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_clear_blocked();
    test_simultaneous();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
